avg_window: RTL and testbench
=============================

Name: avg_window

Overview:
Parametrised sliding-window moving-average filter, the next-generation replacement for the fixed 8-tap, 8-bit averager.
- Uses a running-sum datapath (add newest, subtract oldest) over a circular sample buffer, so the adder count is independent of depth.
- Adds an input valid qualifier, output valid, synchronous flush, optional rounding and optional warm-up suppression.
- Sits in the sample path between an ADC/sensor front end and downstream decimation/threshold logic.

Parameters:
- DATA_W, 8: sample and average width in bits; unsigned.
- LOG2_DEPTH, 3: window depth N = 2**LOG2_DEPTH; legal range 1..8.
- ROUND, 0: 0 = truncate (floor) the average; 1 = round half-up.
- PRIME, 0: 0 = window starts zero-filled and out_valid follows every accepted sample; 1 = out_valid is suppressed until N samples have been accepted since reset/clear.

Ports:
- clk, in, 1: rising-edge clock, sole clock domain.
- rs, in, 1: asynchronous, active-low reset (asserted when 0); release is synchronised externally.
- clear, in, 1: synchronous flush of window, sum and fill count.
- in_valid, in, 1: num_in is accepted on this cycle.
- num_in, in, DATA_W: unsigned input sample.
- out_valid, out, 1: ave holds a new result this cycle (1-cycle pulse per accepted sample).
- ave, out, DATA_W: window average, registered.
- full, out, 1: N or more samples have been accepted since reset/clear.

Behaviour:
- Reset (rs=0, asynchronous), all of the following are cleared immediately, independent of clk:
  - buffer contents, write pointer, running sum and fill count go to 0;
  - ave=0, out_valid=0, full=0.
- Accepted sample (in_valid=1, clear=0), on that edge:
  - sum_nxt = sum + num_in - buf[wr_ptr];
  - buf[wr_ptr] <= num_in;
  - wr_ptr <= wr_ptr+1, wrapping modulo N with no special case at N-1 -> 0;
  - sum <= sum_nxt;
  - fill count increments and saturates at N.
- Sum width is DATA_W+LOG2_DEPTH and never overflows. Subtraction is exact because the buffer always holds the samples that make up sum.
- Result:
  - ROUND=0: ave <= sum_nxt >> LOG2_DEPTH.
  - ROUND=1: ave <= (sum_nxt + 2**(LOG2_DEPTH-1)) >> LOG2_DEPTH. Compute in DATA_W+LOG2_DEPTH bits; the maximum is provably 2**DATA_W-1, so no saturation logic is needed.
- Latency: ave/out_valid update on the same edge that accepts the sample, i.e. visible the cycle after in_valid.
- out_valid:
  - PRIME=0: out_valid = 1 for each accepted sample.
  - PRIME=1: out_valid = 1 only when the post-increment fill count equals N. The N-th sample produces the first pulse.
  - ave is still updated on every accepted sample in both modes.
- full: asserted on the edge that accepts the N-th sample; stays high until reset/clear.
- No accepted sample (in_valid=0): sum, buffer, ave and full hold; out_valid=0.
- clear=1, on that edge:
  - buffer, sum, wr_ptr and fill count go to 0;
  - ave=0, out_valid=0, full=0.
  - clear has priority over in_valid; a sample presented with clear is discarded.
- No backpressure: every in_valid sample is consumed.

Decomposition:
- Package avg_pkg holds:
  - localparam helpers: sum width = DATA_W+LOG2_DEPTH; depth N;
  - a rounding-constant function.
- Sub-module avg_ring_buf:
  - N x DATA_W circular buffer with wrapping write pointer;
  - combinational read of the oldest entry;
  - clear and async reset;
  - exports the write pointer.
- The top level holds the sum, fill counter, rounding and output registers.

Test Plan:
- Defaults (8b, N=8, ROUND=0, PRIME=0): after reset, 8 consecutive samples of 16 -> ave = 2,4,6,8,10,12,14,16, one out_valid per sample; full rises with the 8th.
- Same config, 8x 255 then 8x 0 -> ave reaches 255, then 223,191,159,127,95,63,31,0. With ROUND=1 the tail becomes 223,191,159,128,96,64,32,0.
- Gapped in_valid (sample 40 every 3rd cycle, 10 samples) -> ave/full hold between samples; out_valid pulses exactly 10 times; final ave 40 after wrap past pointer 7 -> 0.
- PRIME=1, samples 1..8 -> out_valid first high with sample 8, ave=4 (36>>3); samples 9,10 -> ave=5,6 (44>>3, 52>>3), out_valid each.
- clear asserted with in_valid=1 / num_in=99 mid-stream -> next cycle ave=0, full=0, out_valid=0, sample dropped. Next sample 80 -> ave=10.
- rs driven low between clock edges mid-stream -> outputs zero immediately without a clk edge; after release, behaviour matches the first scenario.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared sizing helpers for the sliding-window averager.
package avg_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_LOG2_DEPTH = 3;

    // Running-sum width: a full window of max samples fits without overflow.
    function automatic int sum_width(int data_w, int log2_depth);
        return data_w + log2_depth;
    endfunction

    // Window depth N.
    function automatic int depth(int log2_depth);
        return 1 << log2_depth;
    endfunction

    // Constant added before the divide-by-shift: half an LSB of the result
    // when rounding, zero when truncating.
    function automatic int round_const(int log2_depth, bit round);
        return round ? (1 << (log2_depth - 1)) : 0;
    endfunction

endpackage

// File: rtl/avg_window_if.sv
// Sample-stream interface: upstream source drives samples/flush,
// the averager returns the window average and status.
interface avg_window_if #(
    parameter int DATA_W = 8
);
    logic              clear;
    logic              in_valid;
    logic [DATA_W-1:0] num_in;
    logic              out_valid;
    logic [DATA_W-1:0] ave;
    logic              full;

    modport master (output clear, in_valid, num_in,
                    input  out_valid, ave, full);
    modport slave  (input  clear, in_valid, num_in,
                    output out_valid, ave, full);
endinterface

// File: rtl/avg_ring_buf.sv
// Circular sample store; the slot under the write pointer is always the
// oldest sample, so it is read combinationally for the running-sum subtract.
module avg_ring_buf
    import avg_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH
) (
    input  logic                  clk,
    input  logic                  rs,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     oldest,
    output logic [LOG2_DEPTH-1:0] wr_ptr
);
    localparam int N = depth(LOG2_DEPTH);

    logic [DATA_W-1:0] mem [N];

    // Write newest over oldest; pointer wraps naturally at its width.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            for (int i = 0; i < N; i++) mem[i] <= '0;
            wr_ptr <= '0;
        end else if (wr_en) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= wr_ptr + 1'b1;
        end
    end

    assign oldest = mem[wr_ptr];

endmodule

// File: rtl/avg_window.sv
// Sliding-window moving average: running sum (add newest, drop oldest)
// over a circular buffer, registered average with optional rounding and
// optional suppression of output until the window has filled.
module avg_window
    import avg_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
    parameter int ROUND      = 0,
    parameter int PRIME      = 0
) (
    input  logic         clk,
    input  logic         rs,
    avg_window_if.slave  bus
);
    localparam int N     = depth(LOG2_DEPTH);
    localparam int SUM_W = sum_width(DATA_W, LOG2_DEPTH);
    localparam int RND   = round_const(LOG2_DEPTH, ROUND != 0);
    localparam logic [LOG2_DEPTH:0] FILL_MAX = (LOG2_DEPTH+1)'(N);

    logic                  accept;
    logic [DATA_W-1:0]     oldest;
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [SUM_W-1:0]      sum, sum_nxt, rnd_sum;
    logic [LOG2_DEPTH:0]   fill, fill_nxt;
    logic [DATA_W-1:0]     ave_q, ave_nxt;
    logic                  out_valid_q, full_q;

    // A sample presented together with clear is discarded.
    assign accept = bus.in_valid & ~bus.clear;

    avg_ring_buf #(.DATA_W(DATA_W), .LOG2_DEPTH(LOG2_DEPTH)) u_ring (
        .clk     (clk),
        .rs      (rs),
        .clear   (bus.clear),
        .wr_en   (accept),
        .wr_data (bus.num_in),
        .oldest  (oldest),
        .wr_ptr  (wr_ptr)
    );

    // Next sum, rounded average and saturating fill count.
    always_comb begin
        sum_nxt  = sum + SUM_W'(bus.num_in) - SUM_W'(oldest);
        rnd_sum  = sum_nxt + SUM_W'(RND);
        ave_nxt  = DATA_W'(rnd_sum >> LOG2_DEPTH);
        fill_nxt = (fill == FILL_MAX) ? fill : fill + 1'b1;
    end

    // Sum, fill and output registers; ave/full hold when idle.
    always_ff @(posedge clk or negedge rs) begin
        if (!rs) begin
            sum         <= '0;
            fill        <= '0;
            ave_q       <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else if (bus.clear) begin
            sum         <= '0;
            fill        <= '0;
            ave_q       <= '0;
            out_valid_q <= 1'b0;
            full_q      <= 1'b0;
        end else if (accept) begin
            sum         <= sum_nxt;
            fill        <= fill_nxt;
            ave_q       <= ave_nxt;
            out_valid_q <= (PRIME == 0) || (fill_nxt == FILL_MAX);
            full_q      <= (fill_nxt == FILL_MAX);
        end else begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.ave       = ave_q;
    assign bus.out_valid = out_valid_q;
    assign bus.full      = full_q;

endmodule

// File: tb/tb_avg_window.sv
// Scoreboard bench: three averagers (default, rounding, primed) driven by
// directed samples; expected results are queued at issue and checked by a
// monitor whenever out_valid pulses.
module tb_avg_window;

    typedef struct {
        int ave;
        int full;
    } exp_t;

    logic clk = 1'b0;
    logic rs  = 1'b0;
    always #5 clk = ~clk;

    logic       clr [3];
    logic       iv  [3];
    logic [7:0] num [3];
    logic       ov  [3];
    logic [7:0] ave [3];
    logic       full[3];

    avg_window_if #(.DATA_W(8)) b0 ();
    avg_window_if #(.DATA_W(8)) b1 ();
    avg_window_if #(.DATA_W(8)) b2 ();

    assign b0.clear = clr[0]; assign b0.in_valid = iv[0]; assign b0.num_in = num[0];
    assign b1.clear = clr[1]; assign b1.in_valid = iv[1]; assign b1.num_in = num[1];
    assign b2.clear = clr[2]; assign b2.in_valid = iv[2]; assign b2.num_in = num[2];
    assign ov[0] = b0.out_valid; assign ave[0] = b0.ave; assign full[0] = b0.full;
    assign ov[1] = b1.out_valid; assign ave[1] = b1.ave; assign full[1] = b1.full;
    assign ov[2] = b2.out_valid; assign ave[2] = b2.ave; assign full[2] = b2.full;

    avg_window #(.DATA_W(8), .LOG2_DEPTH(3), .ROUND(0), .PRIME(0)) dut0 (.clk(clk), .rs(rs), .bus(b0));
    avg_window #(.DATA_W(8), .LOG2_DEPTH(3), .ROUND(1), .PRIME(0)) dut1 (.clk(clk), .rs(rs), .bus(b1));
    avg_window #(.DATA_W(8), .LOG2_DEPTH(3), .ROUND(0), .PRIME(1)) dut2 (.clk(clk), .rs(rs), .bus(b2));

    exp_t q0[$], q1[$], q2[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses[3] = '{0, 0, 0};

    task automatic chk(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (ov[d]) begin
                exp_t e;
                bit   have;
                have = 1'b0;
                e    = '{0, 0};
                pulses[d]++;
                case (d)
                    0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                    1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                    default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
                endcase
                if (!have) chk($sformatf("dut%0d unexpected out_valid", d), 1, 0);
                else begin
                    chk($sformatf("dut%0d ave", d), int'(ave[d]), e.ave);
                    chk($sformatf("dut%0d full", d), int'(full[d]), e.full);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(int d, int a, int f);
        exp_t e;
        e = '{a, f};
        case (d)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // One accepted sample; queue an expectation if a pulse is due.
    task automatic send(int d, int v, int a, int f, bit p);
        if (p) push(d, a, f);
        num[d] = 8'(v);
        iv[d]  = 1'b1;
        cyc();
        iv[d]  = 1'b0;
    endtask

    task automatic idle(int d, int n, int a, int f);
        repeat (n) begin
            cyc();
            chk($sformatf("dut%0d hold out_valid", d), int'(ov[d]), 0);
            chk($sformatf("dut%0d hold ave", d), int'(ave[d]), a);
            chk($sformatf("dut%0d hold full", d), int'(full[d]), f);
        end
    endtask

    task automatic do_clear(int d, bit with_sample);
        clr[d] = 1'b1;
        iv[d]  = with_sample;
        num[d] = 8'd99;
        cyc();
        clr[d] = 1'b0;
        iv[d]  = 1'b0;
        chk($sformatf("dut%0d clear ave", d), int'(ave[d]), 0);
        chk($sformatf("dut%0d clear full", d), int'(full[d]), 0);
        chk($sformatf("dut%0d clear out_valid", d), int'(ov[d]), 0);
    endtask

    int ramp_t [8] = '{31, 63, 95, 127, 159, 191, 223, 255};
    int tail_t [8] = '{223, 191, 159, 127, 95, 63, 31, 0};
    int ramp_r [8] = '{32, 64, 96, 128, 159, 191, 223, 255};
    int tail_r [8] = '{223, 191, 159, 128, 96, 64, 32, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int p0;
        for (int d = 0; d < 3; d++) begin
            clr[d] = 1'b0; iv[d] = 1'b0; num[d] = 8'd0;
        end
        rs = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("dut%0d reset ave", d), int'(ave[d]), 0);
            chk($sformatf("dut%0d reset full", d), int'(full[d]), 0);
            chk($sformatf("dut%0d reset out_valid", d), int'(ov[d]), 0);
        end
        @(negedge clk);
        rs = 1'b1;
        cyc();

        // 8 x 16: ave climbs 2..16, full with the 8th
        for (int k = 1; k <= 8; k++) send(0, 16, 2 * k, (k == 8) ? 1 : 0, 1'b1);
        idle(0, 1, 16, 1);

        // 8 x 255 then 8 x 0, truncating
        do_clear(0, 1'b0);
        for (int k = 0; k < 8; k++) send(0, 255, ramp_t[k], (k == 7) ? 1 : 0, 1'b1);
        for (int k = 0; k < 8; k++) send(0, 0, tail_t[k], 1, 1'b1);
        idle(0, 1, 0, 1);

        // gapped samples of 40, pointer wraps past 7
        do_clear(0, 1'b0);
        p0 = pulses[0];
        for (int k = 1; k <= 10; k++) begin
            send(0, 40, 5 * ((k > 8) ? 8 : k), (k >= 8) ? 1 : 0, 1'b1);
            idle(0, 2, 5 * ((k > 8) ? 8 : k), (k >= 8) ? 1 : 0);
        end
        chk("gapped pulse count", pulses[0] - p0, 10);

        // clear wins over a simultaneous sample
        send(0, 40, 40, 1, 1'b1);
        do_clear(0, 1'b1);
        send(0, 80, 10, 0, 1'b1);
        idle(0, 1, 10, 0);

        // asynchronous reset between edges
        send(0, 16, 12, 0, 1'b1);
        @(negedge clk);
        #1;
        chk("pre-reset out_valid", int'(ov[0]), 1);
        rs = 1'b0;
        #1;
        chk("async reset ave", int'(ave[0]), 0);
        chk("async reset full", int'(full[0]), 0);
        chk("async reset out_valid", int'(ov[0]), 0);
        #1;
        rs = 1'b1;
        cyc();
        for (int k = 1; k <= 8; k++) send(0, 16, 2 * k, (k == 8) ? 1 : 0, 1'b1);
        idle(0, 1, 16, 1);

        // rounding configuration
        for (int k = 0; k < 8; k++) send(1, 255, ramp_r[k], (k == 7) ? 1 : 0, 1'b1);
        for (int k = 0; k < 8; k++) send(1, 0, tail_r[k], 1, 1'b1);
        idle(1, 1, 0, 1);

        // primed configuration: first pulse on the 8th sample
        p0 = pulses[2];
        for (int k = 1; k <= 8; k++) begin
            send(2, k, 4, 1, k == 8);
            chk("primed full", int'(full[2]), (k == 8) ? 1 : 0);
        end
        send(2, 9, 5, 1, 1'b1);
        send(2, 10, 6, 1, 1'b1);
        idle(2, 2, 6, 1);
        chk("primed pulse count", pulses[2] - p0, 3);

        cyc();
        chk("dut0 leftover expectations", q0.size(), 0);
        chk("dut1 leftover expectations", q1.size(), 0);
        chk("dut2 leftover expectations", q2.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
